// File: rtl/mem_lsu_if.sv
// mem_lsu_if: groups the execute-side op handshake and the split data bus of mem_lsu.
//   Execute side : in_valid/in_ready, in_read, in_write, in_size, in_zext, in_addr, in_wdata, flush
//   Request bus  : dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
//   Response bus : dresp_addr_ok, dresp_data_ok, dresp_data
//   Completion   : out_valid, out_rdata, out_misalign, busy
// modport master is the LSU view; modport slave is the execute/bus environment view.
interface mem_lsu_if #(
  parameter int unsigned XLEN = 64
);
  logic              in_valid;
  logic              in_ready;
  logic              in_read;
  logic              in_write;
  logic [2:0]        in_size;
  logic              in_zext;
  logic [XLEN-1:0]   in_addr;
  logic [XLEN-1:0]   in_wdata;
  logic              flush;
  logic              dreq_valid;
  logic [XLEN-1:0]   dreq_addr;
  logic [2:0]        dreq_size;
  logic [XLEN/8-1:0] dreq_strobe;
  logic [XLEN-1:0]   dreq_data;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [XLEN-1:0]   dresp_data;
  logic              out_valid;
  logic [XLEN-1:0]   out_rdata;
  logic              out_misalign;
  logic              busy;

  modport master (
    input  in_valid, in_read, in_write, in_size, in_zext, in_addr, in_wdata, flush,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    output in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output out_valid, out_rdata, out_misalign, busy
  );

  modport slave (
    output in_valid, in_read, in_write, in_size, in_zext, in_addr, in_wdata, flush,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    input  in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  out_valid, out_rdata, out_misalign, busy
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit for the memory stage.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : mem_lsu_if.master (execute handshake, split addr/data bus, completion)
// Aligns store data/strobes onto byte lanes, extracts and extends load data, faults
// oversized or misaligned ops without touching the bus, and lets a flush squash an op
// while still finishing any bus handshake already started.
module mem_lsu #(
  parameter int unsigned XLEN        = 64,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  mem_lsu_if.master bus
);
  localparam int unsigned SW   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(SW);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            kill_q, kill_d;
  logic            store_q, store_d;
  logic            zext_q, zext_d;
  logic            dreq_valid_q, dreq_valid_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      size_q, size_d;
  logic [SW-1:0]   strobe_q, strobe_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_misalign_q, out_misalign_d;
  logic [XLEN-1:0] out_rdata_q, out_rdata_d;

  logic [OFFW-1:0] off_in;
  logic [OFFW-1:0] align_mask;
  logic            fault;
  logic            ready;
  logic            accept;
  logic [SW-1:0]   st_strobe;
  logic [XLEN-1:0] ld_shifted;
  logic [XLEN-1:0] ld_ext;
  logic            ld_sign;
  int unsigned     ld_bits;

  // Op decode: fault check and acceptance (flush blocks a same-cycle accept).
  assign off_in     = bus.in_addr[OFFW-1:0];
  assign align_mask = OFFW'((8'd1 << bus.in_size) - 8'd1);
  assign fault      = (bus.in_size > 3'(OFFW)) ||
                      (ALIGN_CHECK && ((off_in & align_mask) != '0));
  assign ready      = (state_q == IDLE) && !out_valid_q;
  assign accept     = bus.in_valid && ready && (bus.in_read || bus.in_write) && !bus.flush;

  // Store byte enables: 2^size lanes starting at the address offset, clipped to the word.
  always_comb begin
    st_strobe = '0;
    for (int i = 0; i < int'(SW); i++) begin
      if (i >= int'(off_in) && i < int'(off_in) + (1 << int'(bus.in_size)))
        st_strobe[i] = 1'b1;
    end
  end

  // Load lane extraction and zero/sign extension from the latched op attributes.
  always_comb begin
    ld_shifted = bus.dresp_data >> {addr_q[OFFW-1:0], 3'b000};
    ld_bits    = 32'd8 << size_q;
    case (size_q)
      3'd0:    ld_sign = ld_shifted[7];
      3'd1:    ld_sign = ld_shifted[15];
      3'd2:    ld_sign = ld_shifted[31];
      default: ld_sign = ld_shifted[XLEN-1];
    endcase
    ld_ext = '0;
    for (int i = 0; i < int'(XLEN); i++)
      ld_ext[i] = (32'(i) < ld_bits) ? ld_shifted[i] : (ld_sign && !zext_q);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      kill_q         <= 1'b0;
      store_q        <= 1'b0;
      zext_q         <= 1'b0;
      dreq_valid_q   <= 1'b0;
      addr_q         <= '0;
      size_q         <= '0;
      strobe_q       <= '0;
      data_q         <= '0;
      out_valid_q    <= 1'b0;
      out_misalign_q <= 1'b0;
      out_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      kill_q         <= kill_d;
      store_q        <= store_d;
      zext_q         <= zext_d;
      dreq_valid_q   <= dreq_valid_d;
      addr_q         <= addr_d;
      size_q         <= size_d;
      strobe_q       <= strobe_d;
      data_q         <= data_d;
      out_valid_q    <= out_valid_d;
      out_misalign_q <= out_misalign_d;
      out_rdata_q    <= out_rdata_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    kill_d         = kill_q;
    store_d        = store_q;
    zext_d         = zext_q;
    dreq_valid_d   = dreq_valid_q;
    addr_d         = addr_q;
    size_d         = size_q;
    strobe_d       = strobe_q;
    data_d         = data_q;
    out_valid_d    = 1'b0;
    out_misalign_d = 1'b0;
    out_rdata_d    = '0;

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (accept) begin
          if (fault) begin
            state_d        = RESP;
            out_valid_d    = 1'b1;
            out_misalign_d = 1'b1;
          end else begin
            state_d      = ADDR;
            dreq_valid_d = 1'b1;
            store_d      = bus.in_write;
            zext_d       = bus.in_zext;
            addr_d       = bus.in_addr;
            size_d       = bus.in_size;
            strobe_d     = bus.in_write ? st_strobe : '0;
            data_d       = bus.in_write ? (bus.in_wdata << {off_in, 3'b000}) : '0;
          end
        end
      end
      ADDR, DATA: begin
        // A flush only marks the op dead; the bus handshake still runs to completion.
        if (bus.flush) kill_d = 1'b1;
        if (state_q == ADDR && bus.dresp_addr_ok) begin
          dreq_valid_d = 1'b0;
          state_d      = DATA;
        end
        if (bus.dresp_data_ok && (state_q == DATA || bus.dresp_addr_ok)) begin
          state_d     = IDLE;
          kill_d      = 1'b0;
          out_valid_d = !(kill_q || bus.flush);
          out_rdata_d = (store_q || kill_q || bus.flush) ? '0 : ld_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The fault pulse is presented while in RESP, so a flush in that cycle masks it.
  assign bus.in_ready     = ready;
  assign bus.busy         = (state_q != IDLE);
  assign bus.dreq_valid   = dreq_valid_q;
  assign bus.dreq_addr    = addr_q;
  assign bus.dreq_size    = size_q;
  assign bus.dreq_strobe  = strobe_q;
  assign bus.dreq_data    = data_q;
  assign bus.out_valid    = out_valid_q && !(state_q == RESP && bus.flush);
  assign bus.out_misalign = out_misalign_q && !(state_q == RESP && bus.flush);
  assign bus.out_rdata    = out_rdata_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu at XLEN=64 and XLEN=32 with hand-computed results.
module tb_mem_lsu;
  logic clk = 1'b0;
  logic rst64 = 1'b1;
  logic rst32 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_lsu_if #(.XLEN(64)) b64 ();
  mem_lsu_if #(.XLEN(32)) b32 ();

  mem_lsu #(.XLEN(64), .ALIGN_CHECK(1'b1)) dut64 (.clk(clk), .reset(rst64), .bus(b64.master));
  mem_lsu #(.XLEN(32), .ALIGN_CHECK(1'b1)) dut32 (.clk(clk), .reset(rst32), .bus(b32.master));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Offer one op to the 64-bit unit for the current cycle.
  task automatic offer64(input bit wr, input logic [2:0] sz, input bit zx,
                         input logic [63:0] a, input logic [63:0] wd);
    b64.in_valid = 1'b1;
    b64.in_read  = !wr;
    b64.in_write = wr;
    b64.in_size  = sz;
    b64.in_zext  = zx;
    b64.in_addr  = a;
    b64.in_wdata = wd;
  endtask

  task automatic offer32(input bit wr, input logic [2:0] sz, input bit zx,
                         input logic [31:0] a);
    b32.in_valid = 1'b1;
    b32.in_read  = !wr;
    b32.in_write = wr;
    b32.in_size  = sz;
    b32.in_zext  = zx;
    b32.in_addr  = a;
    b32.in_wdata = '0;
  endtask

  task automatic idle_inputs();
    b64.in_valid = 0; b64.in_read = 0; b64.in_write = 0; b64.flush = 0;
    b64.dresp_addr_ok = 0; b64.dresp_data_ok = 0;
    b32.in_valid = 0; b32.in_read = 0; b32.in_write = 0; b32.flush = 0;
    b32.dresp_addr_ok = 0; b32.dresp_data_ok = 0;
  endtask

  // Byte load at 0x1003 with both oks one cycle after accept.
  task automatic lb_test(input bit zx, input logic [63:0] exp);
    offer64(1'b0, 3'd0, zx, 64'h1003, 64'h0);
    cyc();
    idle_inputs();
    check("lb_dreq_valid", 64'(b64.dreq_valid), 64'd1);
    check("lb_strobe", 64'(b64.dreq_strobe), 64'h0);
    b64.dresp_addr_ok = 1; b64.dresp_data_ok = 1;
    b64.dresp_data = 64'h0000_0000_8000_0000;
    cyc();
    idle_inputs();
    check("lb_out_valid", 64'(b64.out_valid), 64'd1);
    check("lb_rdata", b64.out_rdata, exp);
    check("lb_in_ready_busy_pulse", 64'(b64.in_ready), 64'd0);
    cyc();
    check("lb_pulse_end", 64'(b64.out_valid), 64'd0);
    check("lb_in_ready_after", 64'(b64.in_ready), 64'd1);
  endtask

  initial begin
    b64.in_size = 0; b64.in_zext = 0; b64.in_addr = 0; b64.in_wdata = 0; b64.dresp_data = 0;
    b32.in_size = 0; b32.in_zext = 0; b32.in_addr = 0; b32.in_wdata = 0; b32.dresp_data = 0;
    idle_inputs();
    cyc();
    check("rst_out_valid", 64'(b64.out_valid), 64'd0);
    check("rst_dreq_valid", 64'(b64.dreq_valid), 64'd0);
    check("rst_in_ready", 64'(b64.in_ready), 64'd1);
    check("rst_busy", 64'(b64.busy), 64'd0);
    rst64 = 1'b0; rst32 = 1'b0;
    cyc();

    lb_test(1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    lb_test(1'b1, 64'h0000_0000_0000_0080);

    // Halfword store at 0x1006.
    offer64(1'b1, 3'd1, 1'b0, 64'h1006, 64'hBEEF);
    cyc();
    idle_inputs();
    check("sh_strobe", 64'(b64.dreq_strobe), 64'hC0);
    check("sh_data", b64.dreq_data, 64'hBEEF_0000_0000_0000);
    check("sh_addr", b64.dreq_addr, 64'h1006);
    check("sh_size", 64'(b64.dreq_size), 64'd1);
    b64.dresp_addr_ok = 1; b64.dresp_data_ok = 1; b64.dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    idle_inputs();
    check("sh_out_valid", 64'(b64.out_valid), 64'd1);
    check("sh_rdata", b64.out_rdata, 64'h0);
    cyc();

    // Misaligned word load: no bus request, fault pulse next cycle.
    offer64(1'b0, 3'd2, 1'b0, 64'h1002, 64'h0);
    cyc();
    idle_inputs();
    check("lw_mis_dreq_valid", 64'(b64.dreq_valid), 64'd0);
    check("lw_mis_out_valid", 64'(b64.out_valid), 64'd1);
    check("lw_mis_flag", 64'(b64.out_misalign), 64'd1);
    cyc();
    check("lw_mis_pulse_end", 64'(b64.out_valid), 64'd0);
    check("lw_mis_ready", 64'(b64.in_ready), 64'd1);

    // Doubleword load with data_ok three cycles after addr_ok.
    offer64(1'b0, 3'd3, 1'b0, 64'h2000, 64'h0);
    cyc();
    idle_inputs();
    check("ld_dreq_t1", 64'(b64.dreq_valid), 64'd1);
    b64.dresp_addr_ok = 1;
    cyc();
    idle_inputs();
    check("ld_dreq_t2", 64'(b64.dreq_valid), 64'd0);
    check("ld_busy_t2", 64'(b64.busy), 64'd1);
    cyc();
    check("ld_out_t3", 64'(b64.out_valid), 64'd0);
    cyc();
    b64.dresp_data_ok = 1; b64.dresp_data = 64'h1122_3344_5566_7788;
    cyc();
    idle_inputs();
    check("ld_out_t5", 64'(b64.out_valid), 64'd1);
    check("ld_rdata", b64.out_rdata, 64'h1122_3344_5566_7788);
    cyc();

    // Store flushed while addr_ok is withheld: handshake completes, no pulse.
    offer64(1'b1, 3'd3, 1'b0, 64'h3000, 64'hCAFE);
    cyc();
    idle_inputs();
    check("sd_dreq_t1", 64'(b64.dreq_valid), 64'd1);
    b64.flush = 1;
    cyc();
    idle_inputs();
    check("sd_dreq_t2", 64'(b64.dreq_valid), 64'd1);
    cyc();
    check("sd_dreq_t3", 64'(b64.dreq_valid), 64'd1);
    b64.dresp_addr_ok = 1; b64.dresp_data_ok = 1;
    cyc();
    idle_inputs();
    check("sd_no_out_valid", 64'(b64.out_valid), 64'd0);
    check("sd_in_ready_t4", 64'(b64.in_ready), 64'd1);
    check("sd_busy_t4", 64'(b64.busy), 64'd0);

    // Flush in IDLE blocks the accept; non-memory op ignored.
    offer64(1'b0, 3'd0, 1'b0, 64'h10, 64'h0);
    b64.flush = 1;
    cyc();
    idle_inputs();
    check("flush_idle_busy", 64'(b64.busy), 64'd0);
    b64.in_valid = 1;
    cyc();
    idle_inputs();
    check("nonmem_busy", 64'(b64.busy), 64'd0);

    // Flush during RESP suppresses the fault pulse.
    offer64(1'b0, 3'd1, 1'b0, 64'h1001, 64'h0);
    cyc();
    idle_inputs();
    b64.flush = 1;
    #1;
    check("resp_flush_out_valid", 64'(b64.out_valid), 64'd0);
    cyc();
    idle_inputs();
    check("resp_flush_idle", 64'(b64.busy), 64'd0);

    // XLEN=32: oversized op faults.
    offer32(1'b0, 3'd3, 1'b0, 32'h0);
    cyc();
    idle_inputs();
    check("x32_size_fault", 64'(b32.out_misalign), 64'd1);
    check("x32_size_fault_valid", 64'(b32.out_valid), 64'd1);
    check("x32_size_no_req", 64'(b32.dreq_valid), 64'd0);
    cyc();

    // XLEN=32: halfword load at offset 2, sign-extended.
    offer32(1'b0, 3'd1, 1'b0, 32'h2);
    cyc();
    idle_inputs();
    b32.dresp_addr_ok = 1; b32.dresp_data_ok = 1; b32.dresp_data = 32'h8001_0000;
    cyc();
    idle_inputs();
    check("x32_lh_rdata", 64'(b32.out_rdata), 64'hFFFF_8001);
    cyc();

    // Reset while the request is pending in ADDR drops dreq_valid at once.
    offer32(1'b0, 3'd2, 1'b0, 32'h10);
    cyc();
    idle_inputs();
    check("x32_addr_dreq", 64'(b32.dreq_valid), 64'd1);
    #2 rst32 = 1'b1;
    #1;
    check("x32_rst_addr_dreq", 64'(b32.dreq_valid), 64'd0);
    check("x32_rst_addr_busy", 64'(b32.busy), 64'd0);
    cyc();
    rst32 = 1'b0;

    // Reset mid-DATA drops busy at once; no completion pulse follows.
    offer32(1'b0, 3'd2, 1'b0, 32'h10);
    cyc();
    idle_inputs();
    b32.dresp_addr_ok = 1;
    cyc();
    idle_inputs();
    check("x32_data_busy", 64'(b32.busy), 64'd1);
    #2 rst32 = 1'b1;
    #1;
    check("x32_rst_data_busy", 64'(b32.busy), 64'd0);
    check("x32_rst_data_dreq", 64'(b32.dreq_valid), 64'd0);
    cyc();
    rst32 = 1'b0;
    b32.dresp_data_ok = 1;
    cyc();
    idle_inputs();
    check("x32_rst_no_pulse", 64'(b32.out_valid), 64'd0);
    check("x32_rst_ready", 64'(b32.in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
